// File: rtl/dff_universal_shift_reg.sv
// WIDTH-bit universal shift register: hold/load/shift/rotate/clear, serial I/O, saturating shift counter.
// Optional stored-parity checking is enabled by defining DFF_USR_PARITY_EN.
module dff_universal_shift_reg #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter int unsigned       CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
`ifdef DFF_USR_PARITY_EN
    input  logic             par_in,
    output logic             parity_err,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             cnt_sat
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             shifted;

    always_comb begin
        q_nxt    = q;
        sout_nxt = sout;
        cnt_nxt  = shift_cnt;
        shifted  = 1'b0;
        if (en) begin
            // Unknown or reserved mode falls through to the hold defaults.
            case (mode)
                MODE_LOAD: begin
                    q_nxt   = d;
                    cnt_nxt = '0;
                end
                MODE_SHL: begin
                    q_nxt    = {q[WIDTH-2:0], sin_l};
                    sout_nxt = q[WIDTH-1];
                    shifted  = 1'b1;
                end
                MODE_SHR: begin
                    q_nxt    = {sin_r, q[WIDTH-1:1]};
                    sout_nxt = q[0];
                    shifted  = 1'b1;
                end
                MODE_ROL: begin
                    q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                    sout_nxt = q[WIDTH-1];
                    shifted  = 1'b1;
                end
                MODE_ROR: begin
                    q_nxt    = {q[0], q[WIDTH-1:1]};
                    sout_nxt = q[0];
                    shifted  = 1'b1;
                end
                MODE_CLEAR: begin
                    q_nxt    = RESET_VAL;
                    sout_nxt = 1'b0;
                    cnt_nxt  = '0;
                end
                default: ;
            endcase
            if (shifted && shift_cnt != CNT_MAX) begin
                cnt_nxt = shift_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q         <= RESET_VAL;
            sout      <= 1'b0;
            shift_cnt <= '0;
        end else begin
            q         <= q_nxt;
            sout      <= sout_nxt;
            shift_cnt <= cnt_nxt;
        end
    end

    assign cnt_sat = (shift_cnt == CNT_MAX);

`ifdef DFF_USR_PARITY_EN
    logic par_q;
    logic par_nxt;

    // Incremental update: a logical shift drops one bit and admits another.
    always_comb begin
        par_nxt = par_q;
        if (en) begin
            case (mode)
                MODE_LOAD:  par_nxt = par_in;
                MODE_SHL:   par_nxt = par_q ^ q[WIDTH-1] ^ sin_l;
                MODE_SHR:   par_nxt = par_q ^ q[0] ^ sin_r;
                MODE_CLEAR: par_nxt = ^RESET_VAL;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q      <= ^RESET_VAL;
            parity_err <= 1'b0;
        end else begin
            par_q      <= par_nxt;
            parity_err <= (^q_nxt) != par_nxt;
        end
    end
`endif

`ifndef SYNTHESIS
    mode_known_a : assert property (@(posedge clk) disable iff (!rst) en |-> !$isunknown(mode))
        else $error("mode is unknown while en is high");
`endif

endmodule

// File: tb/tb_dff_universal_shift_reg.sv
// Directed-vector bench for dff_universal_shift_reg (WIDTH=8, RESET_VAL=0, CNT_W=4).
module tb_dff_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic       par_in;
    logic       parity_err;
    logic [7:0] q;
    logic       sout;
    logic [3:0] shift_cnt;
    logic       cnt_sat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dff_universal_shift_reg #(
        .WIDTH(8),
        .RESET_VAL(8'h00),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .d(d),
        .sin_l(sin_l),
        .sin_r(sin_r),
`ifdef DFF_USR_PARITY_EN
        .par_in(par_in),
        .parity_err(parity_err),
`endif
        .q(q),
        .sout(sout),
        .shift_cnt(shift_cnt),
        .cnt_sat(cnt_sat)
    );

`ifndef DFF_USR_PARITY_EN
    assign parity_err = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one operation across a single rising edge, then settle 1ns past it.
    task automatic op(input logic e, input logic [2:0] m, input logic [7:0] dv,
                      input logic sl, input logic sr);
        en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eq, input logic es,
                             input logic [3:0] ec);
        check({tag, ".q"}, 64'(q), 64'(eq));
        check({tag, ".sout"}, 64'(sout), 64'(es));
        check({tag, ".cnt"}, 64'(shift_cnt), 64'(ec));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00;
        sin_l = 1'b0; sin_r = 1'b0; par_in = 1'b0;
        #12;
        chk_state("reset", 8'h00, 1'b0, 4'd0);
        check("reset.sat", 64'(cnt_sat), 64'(1'b0));
        rst = 1'b1;

        // Async reset between edges
        op(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0);
        check("load_a5.q", 64'(q), 64'h A5);
        #2 rst = 1'b0;
        #1 chk_state("async_rst", 8'h00, 1'b0, 4'd0);
        #3 rst = 1'b1;
        op(1'b0, 3'b000, 8'h00, 1'b0, 1'b0);

        // Load / logical shifts
        op(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
        chk_state("load_81", 8'h81, 1'b0, 4'd0);
        op(1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
        chk_state("shl", 8'h02, 1'b1, 4'd1);
        op(1'b1, 3'b011, 8'h00, 1'b0, 1'b1);
        chk_state("shr", 8'h81, 1'b0, 4'd2);

        // Rotates
        op(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
        op(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        chk_state("ror1", 8'hC0, 1'b1, 4'd1);
        op(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        chk_state("ror2", 8'h60, 1'b0, 4'd2);
        op(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        chk_state("ror3", 8'h30, 1'b0, 4'd3);
        op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
        chk_state("rol1", 8'h60, 1'b0, 4'd4);
        op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
        chk_state("rol2", 8'hC0, 1'b0, 4'd5);
        op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
        chk_state("rol3", 8'h81, 1'b1, 4'd6);

        // Enable low and hold modes
        op(1'b1, 3'b001, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) op(1'b0, 3'b010, 8'hFF, 1'b1, 1'b1);
        chk_state("en_low", 8'h3C, 1'b1, 4'd0);
        op(1'b1, 3'b111, 8'hFF, 1'b1, 1'b1);
        chk_state("rsvd", 8'h3C, 1'b1, 4'd0);
        op(1'b1, 3'b000, 8'hFF, 1'b1, 1'b1);
        chk_state("hold", 8'h3C, 1'b1, 4'd0);

        // Counter saturation
        op(1'b1, 3'b001, 8'h5A, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
            check($sformatf("sat%0d.cnt", i), 64'(shift_cnt), (i >= 15) ? 64'd15 : 64'(i));
            check($sformatf("sat%0d.flag", i), 64'(cnt_sat), (i >= 15) ? 64'd1 : 64'd0);
        end
        chk_state("rol20", 8'hA5, 1'b1, 4'd15);
        op(1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
        chk_state("load_after_sat", 8'h00, 1'b1, 4'd0);
        check("load_after_sat.flag", 64'(cnt_sat), 64'd0);

        // Clear
        op(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0);
        op(1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
        chk_state("shl_ff", 8'hFE, 1'b1, 4'd1);
        op(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
        chk_state("clear", 8'h00, 1'b0, 4'd0);

`ifdef DFF_USR_PARITY_EN
        par_in = 1'b0;
        op(1'b1, 3'b001, 8'h07, 1'b0, 1'b0);
        check("par_bad", 64'(parity_err), 64'd1);
        par_in = 1'b1;
        op(1'b1, 3'b001, 8'h07, 1'b0, 1'b0);
        check("par_good", 64'(parity_err), 64'd0);
        op(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
        check("par_shl", 64'(parity_err), 64'd0);
        op(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
        check("par_clear", 64'(parity_err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
